// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the data-RAM arbiter: FSM state encoding and the
// default parameter values used by ram_arbiter and its round-robin picker.
package ram_arbiter_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_REQUESTERS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector. Searches the request vector starting
// at last+1 and wrapping modulo N; the first asserted request wins.
// Ports:
//   i_req   [N-1:0]      request vector
//   i_last  [IDX_W-1:0]  index of the previous winner
//   o_found              at least one request is asserted
//   o_idx   [IDX_W-1:0]  winning index (0 when o_found is low)
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  int unsigned w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      // Wrap without a modulo so non-power-of-two N stays cheap.
      w_cand = 32'(i_last) + k;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      if (!o_found && i_req[w_cand[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port data RAM (registered address/data/wren, q valid one
// cycle after the address edge) between REQUESTERS cores. Requests are
// granted round-robin, one transaction at a time, each completed by a
// one-cycle ack pulse to the owner.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   req/we  [REQUESTERS]    per-requester request and write flag
//   addr    [REQ*ADDR_W]    flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata   [REQ*WIDTH]     flattened write data, same slicing
//   ack     [REQUESTERS]    one-hot completion pulse
//   rdata   [WIDTH]         last read result, held until the next read completes
//   ram_address/ram_data/ram_wren  to the RAM
//   ram_q                   from the RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned REQUESTERS = DEF_REQUESTERS
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [REQUESTERS-1:0]            req,
  input  logic [REQUESTERS-1:0]            we,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] addr,
  input  logic [REQUESTERS*WIDTH-1:0]      wdata,
  output logic [REQUESTERS-1:0]            ack,
  output logic [WIDTH-1:0]                 rdata,
  output logic [ADDR_WIDTH-1:0]            ram_address,
  output logic [WIDTH-1:0]                 ram_data,
  output logic                             ram_wren,
  input  logic [WIDTH-1:0]                 ram_q
);

  localparam int unsigned IDX_W = $clog2(REQUESTERS);

  arb_state_t              r_state;
  logic [IDX_W-1:0]        r_owner;
  logic [IDX_W-1:0]        r_last;
  logic [REQUESTERS-1:0]   r_ack;
  logic [WIDTH-1:0]        r_rdata;
  logic [ADDR_WIDTH-1:0]   r_ram_address;
  logic [WIDTH-1:0]        r_ram_data;
  logic                    r_ram_wren;

  logic                    w_found;
  logic [IDX_W-1:0]        w_win;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [WIDTH-1:0]        w_win_data;
  logic                    w_win_we;
  logic [REQUESTERS-1:0]   w_owner_onehot;

  rr_picker #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // Slice mux for the current winner.
  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    w_win_we   = 1'b0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_win_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = wdata[i*WIDTH +: WIDTH];
        w_win_we   = we[i];
      end
    end
  end

  assign w_owner_onehot = {{(REQUESTERS-1){1'b0}}, 1'b1} << r_owner;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_owner       <= '0;
      r_last        <= IDX_W'(REQUESTERS - 1);
      r_ack         <= '0;
      r_rdata       <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner       <= w_win;
            r_last        <= w_win;
            r_ram_address <= w_win_addr;
            r_ram_data    <= w_win_data;
            r_ram_wren    <= w_win_we;
            r_state       <= ISSUE;
          end else begin
            r_ram_wren <= 1'b0;
          end
        end
        ISSUE: begin
          // ram_wren still carries the owner's write flag here.
          r_ram_wren <= 1'b0;
          if (r_ram_wren) begin
            r_ack   <= w_owner_onehot;
            r_state <= ACK;
          end else begin
            r_state <= RDWAIT;
          end
        end
        RDWAIT: begin
          r_rdata <= ram_q;
          r_ack   <= w_owner_onehot;
          r_state <= ACK;
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter with a behavioural RAM and a
// transaction-level reference model of arbitration, latency and memory.
module tb_ram_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 16;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*W-1:0]  wdata;
  logic [N-1:0]    ack;
  logic [W-1:0]    rdata;
  logic [AW-1:0]   ram_address;
  logic [W-1:0]    ram_data;
  logic            ram_wren;
  logic [W-1:0]    ram_q;

  ram_arbiter #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .REQUESTERS (N)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  // Behavioural RAM: registered address/data/wren, q from the registered address.
  bit [W-1:0]  ram_mem [0:65535];
  logic [AW-1:0] ram_addr_r;
  always @(posedge clock) begin
    ram_addr_r <= ram_address;
    if (ram_wren) ram_mem[ram_address] <= ram_data;
  end
  assign ram_q = ram_mem[ram_addr_r];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model state
  bit [W-1:0]  mdl_mem [0:65535];
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_cur  = 0;
  int          m_last = N - 1;
  bit          m_we   = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [W-1:0]  m_wdata = '0;
  logic [N-1:0]  e_ack   = '0;
  logic [W-1:0]  e_rdata = '0;
  logic [AW-1:0] e_addr  = '0;
  logic [W-1:0]  e_data  = '0;
  logic          e_wren  = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int log_id[$];
  int log_cyc[$];
  bit hold_mode = 1'b0;
  bit rand_mode = 1'b0;
  logic [N-1:0] prev_ack = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*W +: W] = d;
  endtask

  task automatic new_rand(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), W'($urandom));
  endtask

  // Predicts DUT outputs after the coming edge from the inputs it will sample.
  task automatic mdl_step();
    if (!reset_n) begin
      if (m_busy && m_we && m_age == 0) mdl_mem[m_addr] = m_wdata;
      m_busy = 1'b0; m_last = N - 1;
      e_ack = '0; e_rdata = '0; e_addr = '0; e_data = '0; e_wren = 1'b0;
    end else begin
      e_ack = '0;
      if (m_busy) begin
        m_age++;
        if (m_age == 1) e_wren = 1'b0;
        if (m_we && m_age == 1) begin
          mdl_mem[m_addr] = m_wdata;
          e_ack[m_cur] = 1'b1;
        end
        if (!m_we && m_age == 2) begin
          e_rdata = mdl_mem[m_addr];
          e_ack[m_cur] = 1'b1;
        end
        if (m_age == (m_we ? 2 : 3)) m_busy = 1'b0;
      end else begin
        e_wren = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req[c]) begin
            m_cur = c; m_last = c; m_busy = 1'b1; m_age = 0;
            m_we = we[c]; m_addr = addr[c*AW +: AW]; m_wdata = wdata[c*W +: W];
            e_addr = m_addr; e_data = m_wdata; e_wren = m_we;
            break;
          end
        end
      end
    end
  endtask

  task automatic rand_stim();
    for (int i = 0; i < N; i++) begin
      if (m_busy && m_cur == i) begin
        if ($urandom_range(0, 9) < 2) begin
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*W +: W] = W'($urandom);
        end
        if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
      end else if (!req[i] && !prev_ack[i] && $urandom_range(0, 3) == 0) begin
        new_rand(i);
      end
    end
  endtask

  task automatic cycle();
    mdl_step();
    @(posedge clock);
    #1;
    cyc++;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    chk("ram_data", 32'(ram_data), 32'(e_data));
    chk("ram_wren", 32'(ram_wren), 32'(e_wren));
    if (ack != '0) begin
      log_id.push_back(idx_of(ack));
      log_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (prev_ack[i] && !hold_mode) begin
        if (rand_mode && $urandom_range(0, 1) == 1) new_rand(i);
        else req[i] = 1'b0;
      end
    end
    prev_ack = e_ack;
    if (rand_mode) rand_stim();
  endtask

  task automatic wait_ack(input int i, input int limit, output int n);
    n = 0;
    for (int k = 1; k <= limit; k++) begin
      cycle();
      if (ack[i]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int first;
    int second;
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;

    // Reset with every requester asking to write
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(16'h0100 + i), W'(16'hDEAD));
    repeat (2) begin
      cycle();
      chk("reset_ack", 32'(ack), 32'h0);
      chk("reset_wren", 32'(ram_wren), 32'h0);
    end

    // Round-robin with all four holding reads continuously
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(16'h0040 + i), '0);
    hold_mode = 1'b1;
    reset_n = 1'b1;
    log_id.delete(); log_cyc.delete();
    cycle();
    chk("first_grant_addr", 32'(ram_address), 32'h0040);
    repeat (20) cycle();
    chk("rr_count_ok", 32'(log_id.size() >= 5), 32'h1);
    for (int k = 0; k < 5 && k < log_id.size(); k++) begin
      chk("rr_order", 32'(log_id[k]), 32'(k % N));
      if (k > 0) chk("rr_spacing", 32'(log_cyc[k] - log_cyc[k-1]), 32'd4);
    end
    hold_mode = 1'b0;
    req = '0;
    repeat (8) cycle();

    // Write then read back
    set_req(0, 1'b1, 16'h0010, 16'hBEEF);
    wait_ack(0, 10, n);
    chk("wr_latency", 32'(n), 32'd2);
    cycle();
    set_req(0, 1'b0, 16'h0010, '0);
    wait_ack(0, 10, n);
    chk("rd_latency", 32'(n), 32'd3);
    chk("rd_data", 32'(rdata), 32'hBEEF);
    cycle();

    // Rotation from last winner 2: requester 3 beats 1
    set_req(2, 1'b0, 16'h0010, '0);
    wait_ack(2, 10, n);
    chk("rot_setup", 32'(n), 32'd3);
    cycle();
    set_req(1, 1'b0, 16'h0011, '0);
    set_req(3, 1'b0, 16'h0012, '0);
    log_id.delete(); log_cyc.delete();
    for (int k = 0; k < 20 && log_id.size() < 2; k++) cycle();
    first  = (log_id.size() > 0) ? log_id[0] : -1;
    second = (log_id.size() > 1) ? log_id[1] : -1;
    chk("rot_first", 32'(first), 32'd3);
    chk("rot_second", 32'(second), 32'd1);
    cycle();

    // Requester drops req while its write is in ISSUE
    set_req(1, 1'b1, 16'h0020, 16'h1234);
    cycle();
    req[1] = 1'b0;
    wait_ack(1, 10, n);
    chk("drop_ack", 32'(n), 32'd1);
    cycle();
    set_req(1, 1'b0, 16'h0020, '0);
    wait_ack(1, 10, n);
    chk("drop_readback", 32'(rdata), 32'h1234);
    cycle();

    // Reset while a read sits in RDWAIT
    set_req(2, 1'b0, 16'h0020, '0);
    cycle();
    cycle();
    reset_n = 1'b0;
    req[2] = 1'b0;
    set_req(0, 1'b0, 16'h0010, '0);
    set_req(3, 1'b0, 16'h0020, '0);
    cycle();
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_rdata", 32'(rdata), 32'h0);
    reset_n = 1'b1;
    log_id.delete(); log_cyc.delete();
    for (int k = 0; k < 12 && log_id.size() < 1; k++) cycle();
    first = (log_id.size() > 0) ? log_id[0] : -1;
    chk("post_rst_first", 32'(first), 32'd0);
    repeat (8) cycle();

    // Reset on the edge a write is presented: the write still lands
    set_req(3, 1'b1, 16'h0030, 16'h5A5A);
    cycle();
    chk("rst_wr_wren", 32'(ram_wren), 32'h1);
    reset_n = 1'b0;
    req[3] = 1'b0;
    cycle();
    chk("rst_wr_ack", 32'(ack), 32'h0);
    chk("rst_wr_wren_clr", 32'(ram_wren), 32'h0);
    reset_n = 1'b1;
    cycle();
    set_req(3, 1'b0, 16'h0030, '0);
    wait_ack(3, 10, n);
    chk("rst_wr_landed", 32'(rdata), 32'h5A5A);
    cycle();

    // Randomized traffic against the model
    rand_mode = 1'b1;
    repeat (600) cycle();
    rand_mode = 1'b0;
    req = '0;
    repeat (8) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Shares the single-port data RAM (`RAM_1`: registered address/data/wren, `q` valid one cycle after the address edge) between `REQUESTERS` instruction processors.
- Each requester holds a word-wide read/write request until it receives a one-cycle acknowledge.
- Access is granted round-robin, one transaction at a time.
- The block sits between the cores' memory ports and the RAM instance, replacing per-core private RAMs.

## Interface
Parameters:
- `WIDTH`, 16, data word width
- `ADDR_WIDTH`, 16, RAM address width
- `REQUESTERS`, 4, number of requesters (2..8)

Ports:
- `clock`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `req`  in  REQUESTERS  request per requester, held until its `ack`
- `we`  in  REQUESTERS  1 = write, 0 = read; stable while `req` high
- `addr`  in  REQUESTERS*ADDR_WIDTH  flattened; requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `wdata`  in  REQUESTERS*WIDTH  flattened write data, same slicing
- `ack`  out  REQUESTERS  one-cycle completion pulse, one-hot or zero
- `rdata`  out  WIDTH  read result, valid in the `ack` cycle of a read, held until the next read completes
- `ram_address`  out  ADDR_WIDTH  to `RAM_1.address`
- `ram_data`  out  WIDTH  to `RAM_1.data`
- `ram_wren`  out  1  to `RAM_1.wren`
- `ram_q`  in  WIDTH  from `RAM_1.q`

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, ACK.
- **IDLE**, any `req` high:
  - Pick the winner round-robin: search from `last+1` upward, modulo `REQUESTERS`.
  - Register `owner` := winner and `last` := winner.
  - Drive `ram_address`/`ram_data` from the winner's slice; `ram_wren` := `we[winner]`.
  - Next state ISSUE.
- **IDLE**, no `req`: stay; `ram_wren` = 0.
- **ISSUE**: the RAM samples at this edge.
  - Write: `ram_wren` := 0, go to ACK.
  - Read: go to RDWAIT.
- **RDWAIT**: `rdata` := `ram_q`; go to ACK.
- **ACK**:
  - `ack[owner]` = 1 for exactly this cycle.
  - No arbitration in this cycle; next state IDLE.
  - The requester samples `ack` at the closing edge and may drop or reissue `req` from then on.
- `ram_address` and `ram_data` hold their last values outside ISSUE; only `ram_wren` qualifies them.
- Requester drops `req` mid-transaction: the transaction still completes and `ack` still pulses.
- `we`, `addr` and `wdata` are sampled only in IDLE; later changes are ignored.
- Address arithmetic: none. Addresses pass through unmodified, with no range check.

## Timing
- Reset values: `ack` = 0, `rdata` = 0, `ram_address` = 0, `ram_data` = 0, `ram_wren` = 0.
- Reset state: FSM = IDLE, `owner` = 0, `last` = `REQUESTERS-1`, so requester 0 has first priority.
- Write latency: `req` seen at edge E0 → `ram_wren` high E0..E1, RAM write at E1 → `ack` high E1..E2. Back-to-back writes from one requester: one per 3 cycles.
- Read latency: `req` seen at E0 → RAM address edge E1 → `rdata` captured at E2 → `ack` high E2..E3. One read per 4 cycles.
- Reset mid-operation:
  - All outputs and the FSM return to their reset values at that edge, and no `ack` is issued.
  - A write already presented with `ram_wren` = 1 at that same edge still lands in RAM.
- Simultaneous requests: exactly one winner per IDLE edge. The others wait with `req` held.
- Starvation bound: at most `REQUESTERS-1` transactions ahead of any waiting requester.

## Structure
- Package `ram_arbiter_pkg`: state encoding localparams (IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2, ACK = 2'd3) and default widths.
- Sub-module `rr_picker`, combinational:
  - Inputs: request vector, `last` index.
  - Outputs: `found` and winner index.
  - Reusable for future register-file/ALU sharing.
- Top level holds the FSM, `owner`/`last` registers, the slice mux and the `rdata` register.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles with all `req` high → all outputs 0, no `ack`; after release, first grant goes to requester 0.
- Write-then-read: req0 writes `addr` = 16'h0010, `wdata` = 16'hBEEF → `ack[0]` 2 cycles after the sampling edge; req0 then reads 16'h0010 → `ack[0]` 3 cycles after sampling, with `rdata` = 16'hBEEF.
- Round-robin: requesters 0–3 all hold read requests continuously → ack order 0,1,2,3,0, one every 4 cycles, never two `ack` bits at once.
- Rotation from last winner: after requester 2 finishes, req1 and req3 request together → requester 3 wins, then 1.
- Drop mid-transaction: req1 write to 16'h0020 = 16'h1234, `req` dropped during ISSUE → `ack[1]` still pulses; a later read of 16'h0020 returns 16'h1234.
- Reset mid-read: assert `reset_n` = 0 in RDWAIT → no `ack`, `rdata` = 0, FSM in IDLE, next grant goes to requester 0.
